// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel divider, horizontal/vertical counters,
// registered sync/visible/vblank flags and line/frame strobes.
module vga_timing #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] row,
  output logic [31:0] colu,
  output logic        col_en,
  output logic        hsync,
  output logic        vsync,
  output logic        pix_stb,
  output logic        line_end,
  output logic        frame_end,
  output logic        vblank
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Sync windows as [start, end) in pixels / lines
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam bit COL_EN_RST = (H_VISIBLE != 0) && (V_VISIBLE != 0);

  logic [DW-1:0] d_q, d_d;
  logic [HW-1:0] row_q, row_d;
  logic [VW-1:0] colu_q, colu_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          col_en_q, col_en_d;
  logic          vblank_q, vblank_d;
  logic [31:0]   row_x, colu_x;

  // Divider and raster counter advance; everything holds while en is low
  always_comb begin
    d_d    = d_q;
    row_d  = row_q;
    colu_d = colu_q;
    if (en) begin
      if (d_q == D_LAST) begin
        d_d = '0;
        if (row_q == H_LAST) begin
          row_d = '0;
          if (colu_q == V_LAST) begin
            colu_d = '0;
          end else begin
            colu_d = colu_q + VW'(1);
          end
        end else begin
          row_d = row_q + HW'(1);
        end
      end else begin
        d_d = d_q + DW'(1);
      end
    end
  end

  // Flags decoded from next counter values so they align with row/colu
  always_comb begin
    row_x    = 32'(row_d);
    colu_x   = 32'(colu_d);
    col_en_d = (row_x < H_VISIBLE) && (colu_x < V_VISIBLE);
    vblank_d = (colu_x >= V_VISIBLE);
    hsync_d  = ((row_x >= HS_START) && (row_x < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = ((colu_x >= VS_START) && (colu_x < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // State and registered output flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q      <= '0;
      row_q    <= '0;
      colu_q   <= '0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      col_en_q <= COL_EN_RST;
      vblank_q <= 1'b0;
    end else begin
      d_q      <= d_d;
      row_q    <= row_d;
      colu_q   <= colu_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      col_en_q <= col_en_d;
      vblank_q <= vblank_d;
    end
  end

  // Strobes: only en (and reset) reaches outputs combinationally
  always_comb begin
    pix_stb   = rst_n && en && (d_q == D_LAST);
    line_end  = pix_stb && (row_q == H_LAST);
    frame_end = line_end && (colu_q == V_LAST);
  end

  assign row    = 32'(row_q);
  assign colu   = 32'(colu_q);
  assign col_en = col_en_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign vblank = vblank_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (default, mid-size, tiny) checked
// against a raster model computed from the count of enabled clocks.
module tb_vga_timing;

  typedef struct packed {
    logic [31:0] row;
    logic [31:0] colu;
    logic        col_en;
    logic        hsync;
    logic        vsync;
    logic        pix_stb;
    logic        line_end;
    logic        frame_end;
    logic        vblank;
  } obs_t;

  typedef struct {
    int cd; int hv; int hf; int hs; int hb; int vv; int vf; int vs; int vb; bit pol;
  } cfg_t;

  cfg_t cfg_a = '{cd:2, hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, pol:1'b0};
  cfg_t cfg_b = '{cd:2, hv:16,  hf:2,  hs:3,  hb:3,  vv:6,   vf:2,  vs:2, vb:2,  pol:1'b0};
  cfg_t cfg_c = '{cd:1, hv:4,   hf:1,  hs:2,  hb:1,  vv:3,   vf:1,  vs:1, vb:1,  pol:1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a = 1'b0, rst_n_b = 1'b0, rst_n_c = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic [31:0] row_a, colu_a, row_b, colu_b, row_c, colu_c;
  logic col_en_a, hsync_a, vsync_a, pix_stb_a, line_end_a, frame_end_a, vblank_a;
  logic col_en_b, hsync_b, vsync_b, pix_stb_b, line_end_b, frame_end_b, vblank_b;
  logic col_en_c, hsync_c, vsync_c, pix_stb_c, line_end_c, frame_end_c, vblank_c;

  longint cnt_a = 0, cnt_b = 0, cnt_c = 0;
  int checks = 0;
  int errors = 0;

  vga_timing u_a (
    .clk(clk), .rst_n(rst_n_a), .en(en_a), .row(row_a), .colu(colu_a),
    .col_en(col_en_a), .hsync(hsync_a), .vsync(vsync_a), .pix_stb(pix_stb_a),
    .line_end(line_end_a), .frame_end(frame_end_a), .vblank(vblank_a)
  );

  vga_timing #(
    .CLK_DIV(2), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b0)
  ) u_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .row(row_b), .colu(colu_b),
    .col_en(col_en_b), .hsync(hsync_b), .vsync(vsync_b), .pix_stb(pix_stb_b),
    .line_end(line_end_b), .frame_end(frame_end_b), .vblank(vblank_b)
  );

  vga_timing #(
    .CLK_DIV(1), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b1)
  ) u_c (
    .clk(clk), .rst_n(rst_n_c), .en(en_c), .row(row_c), .colu(colu_c),
    .col_en(col_en_c), .hsync(hsync_c), .vsync(vsync_c), .pix_stb(pix_stb_c),
    .line_end(line_end_c), .frame_end(frame_end_c), .vblank(vblank_c)
  );

  // Expected outputs after cnt enabled clocks since reset release
  function automatic obs_t model(cfg_t c, longint cnt, bit en, bit in_rst);
    obs_t   m;
    longint ht, vt, pix, d, r, l;
    ht  = longint'(c.hv + c.hf + c.hs + c.hb);
    vt  = longint'(c.vv + c.vf + c.vs + c.vb);
    pix = cnt / c.cd;
    d   = cnt % c.cd;
    r   = pix % ht;
    l   = (pix / ht) % vt;
    m.row       = 32'(r);
    m.colu      = 32'(l);
    m.col_en    = (r < c.hv) && (l < c.vv);
    m.vblank    = (l >= c.vv);
    m.hsync     = (r >= c.hv + c.hf && r < c.hv + c.hf + c.hs) ? c.pol : ~c.pol;
    m.vsync     = (l >= c.vv + c.vf && l < c.vv + c.vf + c.vs) ? c.pol : ~c.pol;
    m.pix_stb   = !in_rst && en && (d == c.cd - 1);
    m.line_end  = m.pix_stb && (r == ht - 1);
    m.frame_end = m.line_end && (l == vt - 1);
    return m;
  endfunction

  function automatic obs_t obs_a();
    return '{row_a, colu_a, col_en_a, hsync_a, vsync_a, pix_stb_a, line_end_a, frame_end_a, vblank_a};
  endfunction
  function automatic obs_t obs_b();
    return '{row_b, colu_b, col_en_b, hsync_b, vsync_b, pix_stb_b, line_end_b, frame_end_b, vblank_b};
  endfunction
  function automatic obs_t obs_c();
    return '{row_c, colu_c, col_en_c, hsync_c, vsync_c, pix_stb_c, line_end_c, frame_end_c, vblank_c};
  endfunction

  // Flag vector {col_en,hsync,vsync,pix_stb,line_end,frame_end,vblank} for printing
  function automatic logic [6:0] fl(obs_t o);
    return {o.col_en, o.hsync, o.vsync, o.pix_stb, o.line_end, o.frame_end, o.vblank};
  endfunction

  // One clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    if (rst_n_a && en_a) cnt_a++;
    if (rst_n_b && en_b) cnt_b++;
    if (rst_n_c && en_c) cnt_c++;
    #1;
  endtask

  task automatic test_reset();
    obs_t e, a;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    repeat (3) tick();
    e = model(cfg_a, 0, en_a, 1'b1); a = obs_a(); checks++;
    if (a !== e) begin errors++;
      $display("FAIL reset_a act row=%0d colu=%0d fl=%b exp row=%0d colu=%0d fl=%b", a.row, a.colu, fl(a), e.row, e.colu, fl(e)); end
    e = model(cfg_b, 0, en_b, 1'b1); a = obs_b(); checks++;
    if (a !== e) begin errors++;
      $display("FAIL reset_b act row=%0d colu=%0d fl=%b exp row=%0d colu=%0d fl=%b", a.row, a.colu, fl(a), e.row, e.colu, fl(e)); end
    e = model(cfg_c, 0, en_c, 1'b1); a = obs_c(); checks++;
    if (a !== e) begin errors++;
      $display("FAIL reset_c act row=%0d colu=%0d fl=%b exp row=%0d colu=%0d fl=%b", a.row, a.colu, fl(a), e.row, e.colu, fl(e)); end
    @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
  endtask

  task automatic test_first_line();
    obs_t e, a;
    int le_cnt = 0;
    int le_at = -1;
    for (int i = 0; i < 1602; i++) begin
      e = model(cfg_a, cnt_a, en_a, 1'b0); a = obs_a(); checks++;
      if (a !== e) begin errors++;
        $display("FAIL first_line i=%0d act row=%0d colu=%0d fl=%b exp row=%0d colu=%0d fl=%b", i, a.row, a.colu, fl(a), e.row, e.colu, fl(e)); end
      if (a.line_end === 1'b1) begin le_cnt++; le_at = i; end
      tick();
    end
    checks++;
    if (le_cnt != 1 || le_at != 1599) begin errors++;
      $display("FAIL line_end_pos act count=%0d at=%0d exp count=1 at=1599", le_cnt, le_at); end
  endtask

  task automatic test_hsync_width();
    obs_t e, a;
    int low = 0;
    int first_row = -1;
    int guard = 0;
    while (cnt_a % 1600 != 0 && guard < 1700) begin tick(); guard++; end
    for (int i = 0; i < 1600; i++) begin
      e = model(cfg_a, cnt_a, en_a, 1'b0); a = obs_a(); checks++;
      if (a !== e) begin errors++;
        $display("FAIL hsync_line i=%0d act row=%0d fl=%b exp row=%0d fl=%b", i, a.row, fl(a), e.row, fl(e)); end
      if (a.hsync === 1'b0) begin
        if (first_row < 0) first_row = int'(a.row);
        low++;
      end
      tick();
    end
    checks++;
    if (low != 192 || first_row != 656) begin errors++;
      $display("FAIL hsync_width act clocks=%0d start=%0d exp clocks=192 start=656", low, first_row); end
  endtask

  task automatic test_full_frame();
    obs_t e, a;
    int fe = 0;
    int vis = 0;
    int guard = 0;
    #2 rst_n_b = 1'b0; cnt_b = 0;
    tick();
    @(negedge clk); rst_n_b = 1'b1;
    while (cnt_b < 1152 && guard < 5000) begin
      en_b = ($urandom_range(0, 9) < 8);
      #1;
      e = model(cfg_b, cnt_b, en_b, 1'b0); a = obs_b(); checks++;
      if (a !== e) begin errors++;
        $display("FAIL frame_b cnt=%0d act row=%0d colu=%0d fl=%b exp row=%0d colu=%0d fl=%b", cnt_b, a.row, a.colu, fl(a), e.row, e.colu, fl(e)); end
      if (a.frame_end === 1'b1) fe++;
      if (a.pix_stb === 1'b1 && a.col_en === 1'b1) vis++;
      tick(); guard++;
    end
    checks++;
    if (guard >= 5000) begin errors++;
      $display("FAIL frame_b_timeout act cnt=%0d exp cnt=1152", cnt_b); end
    checks++;
    if (fe != 2 || vis != 192) begin errors++;
      $display("FAIL frame_b_counts act frame_end=%0d visible=%0d exp frame_end=2 visible=192", fe, vis); end
  endtask

  task automatic test_stall();
    obs_t e, a;
    int guard = 0;
    en_b = 1'b1;
    // Last visible pixel (row 15, line 5), divider at 0
    while (cnt_b % 576 != 270 && guard < 2000) begin
      e = model(cfg_b, cnt_b, en_b, 1'b0); a = obs_b(); checks++;
      if (a !== e) begin errors++;
        $display("FAIL stall_seek cnt=%0d act row=%0d colu=%0d fl=%b exp row=%0d colu=%0d fl=%b", cnt_b, a.row, a.colu, fl(a), e.row, e.colu, fl(e)); end
      tick(); guard++;
    end
    en_b = 1'b0;
    for (int i = 0; i < 37; i++) begin
      #1;
      e = model(cfg_b, cnt_b, en_b, 1'b0); a = obs_b(); checks++;
      if (a !== e || a.row !== 32'd15 || a.colu !== 32'd5) begin errors++;
        $display("FAIL stall_hold i=%0d act row=%0d colu=%0d fl=%b exp row=15 colu=5 fl=%b", i, a.row, a.colu, fl(a), fl(e)); end
      tick();
    end
    en_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      e = model(cfg_b, cnt_b, en_b, 1'b0); a = obs_b(); checks++;
      if (a !== e) begin errors++;
        $display("FAIL stall_resume i=%0d act row=%0d fl=%b exp row=%0d fl=%b", i, a.row, fl(a), e.row, fl(e)); end
      tick();
    end
    checks++;
    if (row_b !== 32'd16 || col_en_b !== 1'b0) begin errors++;
      $display("FAIL stall_after act row=%0d col_en=%b exp row=16 col_en=0", row_b, col_en_b); end
  endtask

  task automatic test_reset_midframe();
    obs_t e, a;
    int guard = 0;
    en_b = 1'b1;
    // Row 20 (inside hsync), line 9 (second vsync line)
    while (cnt_b % 576 != 472 && guard < 2000) begin tick(); guard++; end
    e = model(cfg_b, cnt_b, en_b, 1'b0); a = obs_b(); checks++;
    if (a !== e || a.hsync !== 1'b0 || a.vsync !== 1'b0) begin errors++;
      $display("FAIL pre_reset act row=%0d colu=%0d fl=%b exp row=%0d colu=%0d fl=%b", a.row, a.colu, fl(a), e.row, e.colu, fl(e)); end
    #2 rst_n_b = 1'b0; cnt_b = 0;
    #1;
    e = model(cfg_b, 0, en_b, 1'b1); a = obs_b(); checks++;
    if (a !== e || a.hsync !== 1'b1 || a.row !== 32'd0) begin errors++;
      $display("FAIL async_reset act row=%0d colu=%0d fl=%b exp row=0 colu=0 fl=%b", a.row, a.colu, fl(a), fl(e)); end
    tick();
    @(negedge clk); rst_n_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      e = model(cfg_b, cnt_b, en_b, 1'b0); a = obs_b(); checks++;
      if (a !== e) begin errors++;
        $display("FAIL post_reset i=%0d act row=%0d fl=%b exp row=%0d fl=%b", i, a.row, fl(a), e.row, fl(e)); end
    end
  endtask

  task automatic test_small();
    obs_t e, a;
    int guard = 0;
    int fe_first = -1;
    int fe_second = -1;
    int fe_n = 0;
    #2 rst_n_c = 1'b0; cnt_c = 0;
    tick();
    @(negedge clk); rst_n_c = 1'b1;
    for (int i = 0; i < 200; i++) begin
      en_c = ($urandom_range(0, 3) != 0);
      #1;
      e = model(cfg_c, cnt_c, en_c, 1'b0); a = obs_c(); checks++;
      if (a !== e || a.pix_stb !== en_c) begin errors++;
        $display("FAIL small i=%0d act row=%0d colu=%0d fl=%b exp row=%0d colu=%0d fl=%b", i, a.row, a.colu, fl(a), e.row, e.colu, fl(e)); end
      tick();
    end
    en_c = 1'b1;
    while (cnt_c % 48 != 0 && guard < 100) begin tick(); guard++; end
    for (int i = 0; i < 96; i++) begin
      e = model(cfg_c, cnt_c, en_c, 1'b0); a = obs_c(); checks++;
      if (a !== e) begin errors++;
        $display("FAIL small_run i=%0d act row=%0d colu=%0d fl=%b exp row=%0d colu=%0d fl=%b", i, a.row, a.colu, fl(a), e.row, e.colu, fl(e)); end
      if (a.frame_end === 1'b1) begin
        if (fe_n == 0) fe_first = i; else fe_second = i;
        fe_n++;
      end
      tick();
    end
    checks++;
    if (fe_n != 2 || fe_second - fe_first != 48) begin errors++;
      $display("FAIL small_frame_period act pulses=%0d spacing=%0d exp pulses=2 spacing=48", fe_n, fe_second - fe_first); end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_hsync_width();
    test_full_frame();
    test_stall();
    test_reset_midframe();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates VGA raster timing for the video output path. Produces free-running horizontal and vertical pixel counters (`row`, `colu`), the visible-area enable `col_en`, and `hsync`/`vsync`. Sits directly upstream of the text/graphics pixel generator, which consumes `row`, `colu` and `col_en` to form memory addresses and the output colour. Also drives the VGA connector sync pins and provides line/frame strobes for the video-memory and CPU vblank logic.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; must be ≥1.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: sync active level. 0 = active-low; 1 = active-high.
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: reset. Asynchronous assert, active-low.
- `en` in 1: run enable. When low, all state holds.
- `row` out 32: horizontal pixel counter, 0 to H_TOTAL−1. Upper bits are zero.
- `colu` out 32: vertical line counter, 0 to V_TOTAL−1. Upper bits are zero.
- `col_en` out 1: high when the pixel is in the visible area.
- `hsync` out 1: horizontal sync.
- `vsync` out 1: vertical sync.
- `pix_stb` out 1: high on the last system clock of each pixel.
- `line_end` out 1: one-clock pulse on the last clock of each line.
- `frame_end` out 1: one-clock pulse on the last clock of each frame.
- `vblank` out 1: high when `colu` ≥ V_VISIBLE.

## Operation
- Derived totals: H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (800). V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (525).
- State consists of the divider `d` (0 to CLK_DIV−1), the `row` register and the `colu` register.
- Divider, on each clock edge with `en` = 1:
  - if `d` = CLK_DIV−1: `d` ← 0 and the pixel counters advance;
  - otherwise: `d` ← `d` + 1.
- Pixel counter advance:
  - `row` = H_TOTAL−1 wraps to 0 and `colu` increments.
  - `colu` = V_TOTAL−1 at a line wrap also wraps to 0.
  - Otherwise only `row` increments.
- `en` = 0 freezes `d`, `row`, `colu` and the sync registers. `pix_stb`, `line_end` and `frame_end` are forced low. Operation resumes exactly where it stopped.
- `col_en` = (`row` < H_VISIBLE) && (`colu` < V_VISIBLE).
- hsync is active for `row` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC−1], i.e. 656..751.
- vsync is active for `colu` in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC−1], i.e. 490..491.
- Active level of both syncs = SYNC_POL; inactive level = ~SYNC_POL.
- Strobe decoding:
  - `pix_stb` = `en` && `d` = CLK_DIV−1. With CLK_DIV = 1, `pix_stb` equals `en`.
  - `line_end` = `pix_stb` && `row` = H_TOTAL−1.
  - `frame_end` = `line_end` && `colu` = V_TOTAL−1.
- Output timing:
  - `hsync`, `vsync`, `col_en` and `vblank` are registered. They are computed from the next counter values, so they always correspond to the `row`/`colu` currently presented.
  - Strobes decode from registers only. No combinational path exists from `en` to any output except the strobes.
- Counter widths: internal counters are sized to hold H_TOTAL−1 and V_TOTAL−1, zero-extended to 32 bits. Overflow past the totals never occurs.

## Timing
- Reset (asynchronous, while `rst_n` = 0):
  - `d` = 0, `row` = 0, `colu` = 0.
  - `col_en` = 1, `vblank` = 0.
  - `hsync` = `vsync` = ~SYNC_POL (inactive).
  - `pix_stb` = `line_end` = `frame_end` = 0.
- Reset release: the first counter advance occurs CLK_DIV rising edges after `rst_n` rises, provided `en` = 1.
- Assertion of `rst_n` mid-frame returns all outputs to reset values immediately, without waiting for a clock.
- Each pixel lasts exactly CLK_DIV clocks. `row`/`colu` and all registered outputs change together on the same edge.
- Line length = H_TOTAL × CLK_DIV clocks (1600). Frame length = V_TOTAL × H_TOTAL × CLK_DIV clocks (840000).
- The downstream generator sees `row`/`colu` with zero added latency. Any pipeline compensation is its own responsibility.

## Test plan
- **Reset, then `en` = 1 (default parameters):** `row` = 0 for 2 clocks, then 1. After 1600 clocks, `row` = 0 and `colu` = 1, with `line_end` high on clock 1599 only.
- **Full frame:** `frame_end` pulses exactly once per 840000 clocks. `hsync` is low for 192 contiguous clocks per line, starting at `row` = 656. `vsync` is low while `colu` ∈ {490, 491}. `col_en` is high for exactly 307200 pixels per frame.
- **Stall:** drop `en` for 37 clocks at `row` = 639, `colu` = 479. All counters and syncs hold and the strobes stay 0. On resume, `row` = 640 follows after the remaining divider count and `col_en` falls.
- **Reset mid-frame:** assert `rst_n` = 0 asynchronously at `colu` = 491, `row` = 700. `hsync`/`vsync` go to 1 and the counters go to 0 before the next clock edge.
- **Small parameters (CLK_DIV = 1, H = 4/1/2/1, V = 3/1/1/1, SYNC_POL = 1):**
  - `pix_stb` equals `en`.
  - `row` cycles 0..7.
  - `hsync` is high at rows 5..6.
  - `vsync` is high at `colu` = 4.
  - `frame_end` pulses every 48 clocks.
